seg7_scan: RTL and testbench



---
 rtl/seg7_pkg.sv | 32 +++
 rtl/seg7_scan_if.sv | 35 +++
 rtl/seg7_decode.sv | 34 +++
 rtl/seg7_scan.sv | 114 +++++++++++
 tb/tb_seg7_scan.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pkg
//  Purpose  : Shared glyph constants, digit count and prescaler width helper
//             for the seven-segment scan driver.
//  Revision : 1.0  initial release
// ============================================================================
package seg7_pkg;

    localparam int NDIGITS = 4;

    // Active-high glyphs, bit order g..a (bit0 = a).
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    // Width of a counter that must hold 0..div-1; never narrower than one bit.
    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_if.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_if
//  Purpose  : Bundles the BCD/decimal-point inputs and the display pin
//             outputs of the scan driver.
//  Revision : 1.0  initial release
// ============================================================================
interface seg7_scan_if;

    logic [15:0] i_bcd;
    logic [3:0]  i_dp;
    logic [6:0]  o_seg;
    logic        o_dp;
    logic [3:0]  o_an;

    // Upstream side: supplies the count, observes the pins.
    modport master (
        output i_bcd,
        output i_dp,
        input  o_seg,
        input  o_dp,
        input  o_an
    );

    // Display driver side.
    modport slave (
        input  i_bcd,
        input  i_dp,
        output o_seg,
        output o_dp,
        output o_an
    );

endinterface
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_decode
//  Purpose  : Combinational BCD nibble to active-high seven-segment glyph.
//             Non-BCD nibbles (A-F) render as a dash.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_decode
    import seg7_pkg::*;
(
    input  wire logic [3:0] i_nibble,
    output logic      [6:0] o_glyph
);

    // Glyph lookup; anything outside 0-9 is flagged with a dash.
    always_comb begin
        o_glyph = SEG_DASH;
        case (i_nibble)
            4'd0:    o_glyph = SEG_0;
            4'd1:    o_glyph = SEG_1;
            4'd2:    o_glyph = SEG_2;
            4'd3:    o_glyph = SEG_3;
            4'd4:    o_glyph = SEG_4;
            4'd5:    o_glyph = SEG_5;
            4'd6:    o_glyph = SEG_6;
            4'd7:    o_glyph = SEG_7;
            4'd8:    o_glyph = SEG_8;
            4'd9:    o_glyph = SEG_9;
            default: o_glyph = SEG_DASH;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan
//  Purpose  : Time-multiplexed 4-digit seven-segment driver. Snapshots the
//             BCD value once per frame, scans digits with a prescaler and
//             blanks all anodes for BLANK_CYC cycles at each slot start.
//             Optional macro SEG7_LZB_EN enables leading-zero blanking.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int F0         = 50_000_000,
    parameter int F_SCAN     = 1000,
    parameter int BLANK_CYC  = 2,
    parameter int ACTIVE_LOW = 1
) (
    input  wire logic   clk,
    input  wire logic   rst,
    seg7_scan_if.slave  bus
);

    localparam int         DIV   = F0 / F_SCAN;
    localparam int         CW    = cnt_width(DIV);
    localparam logic       c_INV = (ACTIVE_LOW != 0);

    // Pin-level "off" patterns for the selected polarity.
    localparam logic [3:0] c_AN_OFF  = {4{c_INV}};
    localparam logic [6:0] c_SEG_PIN_OFF = SEG_OFF ^ {7{c_INV}};
    localparam logic       c_DP_OFF  = c_INV;

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [15:0]   r_snap_bcd;
    logic [3:0]    r_snap_dp;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic          w_tick;
    logic          w_slot_blank;
    logic [3:0]    w_nibble;
    logic [6:0]    w_glyph;
    logic [6:0]    w_seg_hi;
    logic [3:0]    w_an_on;

    assign w_tick       = (r_cnt == CW'(DIV - 1));
    assign w_slot_blank = (r_cnt < CW'(BLANK_CYC));
    assign w_nibble     = r_snap_bcd[{r_idx, 2'b00} +: 4];
    assign w_an_on      = (4'b0001 << r_idx) ^ {4{c_INV}};

    seg7_decode u_decode (
        .i_nibble (w_nibble),
        .o_glyph  (w_glyph)
    );

`ifdef SEG7_LZB_EN
    // Digit k>0 is dark when it and every more significant digit are zero.
    logic [3:0] w_lz_blank;
    for (genvar k = 0; k < NDIGITS; k++) begin : g_lzb
        if (k == 0) begin : g_units
            assign w_lz_blank[k] = 1'b0;
        end else begin : g_upper
            assign w_lz_blank[k] = (r_snap_bcd[4*NDIGITS-1:4*k] == '0);
        end
    end
    assign w_seg_hi = w_lz_blank[r_idx] ? SEG_OFF : w_glyph;
`else
    assign w_seg_hi = w_glyph;
`endif

    // Prescaler and digit index; the index advances on the last slot cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            if (w_tick) begin
                r_idx <= r_idx + 2'd1;
            end
        end
    end

    // Capture a new value only at the frame boundary so a frame never tears.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap_bcd <= '0;
            r_snap_dp  <= '0;
        end else if (w_tick && (r_idx == 2'd3)) begin
            r_snap_bcd <= bus.i_bcd;
            r_snap_dp  <= bus.i_dp;
        end
    end

    // Registered pin drive: dark during the guard interval, else one digit lit.
    always_ff @(posedge clk) begin
        if (rst || w_slot_blank) begin
            r_an  <= c_AN_OFF;
            r_seg <= c_SEG_PIN_OFF;
            r_dp  <= c_DP_OFF;
        end else begin
            r_an  <= w_an_on;
            r_seg <= w_seg_hi ^ {7{c_INV}};
            r_dp  <= r_snap_dp[r_idx] ^ c_INV;
        end
    end

    assign bus.o_an  = r_an;
    assign bus.o_seg = r_seg;
    assign bus.o_dp  = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan
//  Purpose  : Self-checking bench for seg7_scan (DIV=10, BLANK_CYC=2,
//             active-low). Expected frames are queued when a value is driven
//             and popped when the DUT displays the corresponding frame.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_scan;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seg7_scan_if bus_if ();

    seg7_scan #(
        .F0         (1000),
        .F_SCAN     (100),
        .BLANK_CYC  (2),
        .ACTIVE_LOW (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // Expected pin values per digit for one frame (active-low pins).
    typedef struct packed {
        logic [3:0][6:0] seg;
        logic [3:0]      dpo;
    } exp_t;

    // Stimulus record: BCD, dp enables, plain pin glyphs, LZB-dark digits.
    typedef struct packed {
        logic [15:0]     bcd;
        logic [3:0]      dp;
        logic [3:0][6:0] seg;
        logic [3:0]      lzb;
    } vec_t;

    localparam int NVEC = 7;

    exp_t sb_q[$];
    vec_t vecs[NVEC];
    vec_t zero_v;
    int   errors = 0;
    int   checks = 0;

    function automatic exp_t make_exp(input vec_t v);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
`ifdef SEG7_LZB_EN
            e.seg[k] = v.lzb[k] ? 7'h7F : v.seg[k];
`else
            e.seg[k] = v.seg[k];
`endif
        end
        e.dpo = ~v.dp;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input int n,
                             input logic [3:0] w_an, input logic [6:0] w_seg,
                             input logic w_dp);
        checks++;
        if (bus_if.o_an !== w_an || bus_if.o_seg !== w_seg || bus_if.o_dp !== w_dp) begin
            errors++;
            $display("FAIL %s cycle=%0d: got an=%b seg=%h dp=%b, want an=%b seg=%h dp=%b",
                     name, n, bus_if.o_an, bus_if.o_seg, bus_if.o_dp, w_an, w_seg, w_dp);
        end
    endtask

    // Checks ncyc cycles of a frame against the oldest queued expectation;
    // at cycle change_at the next vector is driven and its frame queued.
    task automatic check_frame(input string name, input int ncyc,
                               input int change_at, input vec_t nv);
        exp_t e;
        int   k;
        int   c;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: got empty scoreboard, want a queued frame", name);
            return;
        end
        e = sb_q.pop_front();
        for (int n = 1; n <= ncyc; n++) begin
            step();
            k = (n - 1) / 10;
            c = (n - 1) % 10;
            if (c < 2)
                check_out(name, n, 4'b1111, 7'h7F, 1'b1);
            else
                check_out(name, n, ~(4'b0001 << k), e.seg[k], e.dpo[k]);
            if (n == change_at) begin
                bus_if.i_bcd = nv.bcd;
                bus_if.i_dp  = nv.dp;
                sb_q.push_back(make_exp(nv));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //              bcd       dp       d3     d2     d1     d0     lzb
        vecs[0] = {16'h1234, 4'b0000, 7'h79, 7'h24, 7'h30, 7'h19, 4'b0000};
        vecs[1] = {16'h5678, 4'b1000, 7'h12, 7'h02, 7'h78, 7'h00, 4'b0000};
        vecs[2] = {16'h00A0, 4'b0010, 7'h40, 7'h40, 7'h3F, 7'h40, 4'b1100};
        vecs[3] = {16'h0007, 4'b0000, 7'h40, 7'h40, 7'h40, 7'h78, 4'b1110};
        vecs[4] = {16'h9F0B, 4'b0101, 7'h10, 7'h3F, 7'h40, 7'h3F, 4'b0000};
        vecs[5] = {16'h0000, 4'b1111, 7'h40, 7'h40, 7'h40, 7'h40, 4'b1110};
        vecs[6] = {16'h8000, 4'b0000, 7'h00, 7'h40, 7'h40, 7'h40, 4'b0000};
        zero_v  = {16'h0000, 4'b0000, 7'h40, 7'h40, 7'h40, 7'h40, 4'b1110};

        bus_if.i_bcd = 16'h0000;
        bus_if.i_dp  = 4'b0000;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("reset", i, 4'b1111, 7'h7F, 1'b1);
        end
        rst = 1'b0;

        // Frame 0 shows the cleared snapshot; the first vector is driven mid-frame.
        sb_q.push_back(make_exp(zero_v));
        check_frame("frame0", 40, 15, vecs[0]);

        // Each frame shows vecs[i] while vecs[i+1] is driven during digit 1.
        for (int i = 0; i < NVEC; i++) begin
            check_frame($sformatf("vec%0d", i), 40, (i < NVEC - 1) ? 15 : 0,
                        vecs[(i < NVEC - 1) ? i + 1 : i]);
        end

        // Input held, so the next frame repeats the last vector; stop in digit 2.
        sb_q.push_back(make_exp(vecs[NVEC - 1]));
        check_frame("pre_rst", 25, 0, vecs[NVEC - 1]);

        rst = 1'b1;
        step();
        check_out("rst_mid", 0, 4'b1111, 7'h7F, 1'b1);
        step();
        check_out("rst_mid", 1, 4'b1111, 7'h7F, 1'b1);
        rst = 1'b0;

        // Scan restarts at digit 0 with the cleared snapshot.
        sb_q.push_back(make_exp(zero_v));
        check_frame("post_rst", 40, 0, zero_v);

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d frames left, want 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
